// File: rtl/right_logic_shifter.sv
// -----------------------------------------------------------------------------
// right_logic_shifter
//   Parameterised logical right shifter for the ALU shift-right-logical op.
//   y = a >> shift (zero fill), with zero flag z and carry-out c (last bit
//   shifted out). y_q/z_q/c_q are registered copies for pipelined stages.
//
//   Configuration macro: RIGHT_LOGIC_SHIFTER_REG_OUT_EN
//     defined     : y_q/z_q/c_q are flops (1-cycle latency, async reset
//                   to y_q=0, z_q=1, c_q=0).
//     not defined : y_q/z_q/c_q are wired to y/z/c; clk/rst_n unused.
//
// Ports
//   clk    in  1  clock for the registered outputs
//   rst_n  in  1  asynchronous active-low reset
//   a      in  N  operand
//   shift  in  N  unsigned shift amount
//   y      out N  combinational result
//   z      out 1  combinational zero flag
//   c      out 1  combinational carry-out
//   y_q    out N  registered y
//   z_q    out 1  registered z
//   c_q    out 1  registered c
// -----------------------------------------------------------------------------
module right_logic_shifter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] shift,
   output logic [N-1:0] y,
   output logic         z,
   output logic         c,
   output logic [N-1:0] y_q,
   output logic         z_q,
   output logic         c_q
);

   localparam int unsigned L = $clog2(N);

   logic [N:0] v;
   logic       hi;

   // Barrel over {a, guard}: the guard bit ends up holding the last bit
   // shifted out, which is exactly the carry for shift amounts below 2^L.
   always_comb begin
      v = {a, 1'b0};
      for (int k = 0; k < int'(L); k++) begin
         if (shift[k]) v = v >> (1 << k);
      end
      hi = |shift[N-1:L];
      if (hi) begin
         // shift >= 2^L >= N: result is always zero; only shift == N keeps a carry
         y = '0;
         c = (shift == N'(N)) ? a[N-1] : 1'b0;
      end else begin
         y = v[N:1];
         c = v[0];
      end
      z = (y == '0);
   end

`ifdef RIGHT_LOGIC_SHIFTER_REG_OUT_EN
   // Pipeline copy of result and flags; reset value reflects a zero result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
         z_q <= 1'b1;
         c_q <= 1'b0;
      end else begin
         y_q <= y;
         z_q <= z;
         c_q <= c;
      end
   end
`else
   assign y_q = y;
   assign z_q = z;
   assign c_q = c;

   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_right_logic_shifter.sv
// -----------------------------------------------------------------------------
// tb_right_logic_shifter
//   Scoreboard bench: the driver applies (a, shift) on the falling edge and
//   pushes the model's expected response; the monitor pops and compares the
//   combinational outputs mid-cycle and the registered outputs after the
//   following rising edge.
// -----------------------------------------------------------------------------
module tb_right_logic_shifter;

   localparam int unsigned N = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] a;
   logic [N-1:0] shift;
   logic [N-1:0] y;
   logic         z;
   logic         c;
   logic [N-1:0] y_q;
   logic         z_q;
   logic         c_q;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] s;
      logic [N-1:0] y;
      logic         z;
      logic         c;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   right_logic_shifter #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .shift (shift),
      .y     (y),
      .z     (z),
      .c     (c),
      .y_q   (y_q),
      .z_q   (z_q),
      .c_q   (c_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on the shift amount.
   function automatic exp_t model(input logic [N-1:0] aa, input logic [N-1:0] ss);
      exp_t e;
      int   ai;
      int   si;
      ai = int'(aa);
      si = int'(ss);
      e.a = aa;
      e.s = ss;
      if (si >= int'(N)) e.y = '0;
      else               e.y = N'(ai / (2 ** si));
      if (si == 0 || si > int'(N)) e.c = 1'b0;
      else                         e.c = 1'((ai / (2 ** (si - 1))) % 2);
      e.z = (e.y == '0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                      input logic [N-1:0] aa, input logic [N-1:0] ss);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s a=%b shift=%0d got=%0h expected=%0h", name, aa, ss, act, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] aa, input logic [N-1:0] ss);
      @(negedge clk);
      a     = aa;
      shift = ss;
      q.push_back(model(aa, ss));
   endtask

   // Monitor: combinational check mid-cycle, registered check after next edge.
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("y", 32'(y), 32'(e.y), e.a, e.s);
         chk("z", 32'(z), 32'(e.z), e.a, e.s);
         chk("c", 32'(c), 32'(e.c), e.a, e.s);
         @(posedge clk);
         #1;
         if (rst_n) begin
            chk("y_q", 32'(y_q), 32'(e.y), e.a, e.s);
            chk("z_q", 32'(z_q), 32'(e.z), e.a, e.s);
            chk("c_q", 32'(c_q), 32'(e.c), e.a, e.s);
         end
      end
   end

   initial begin
      logic [N-1:0] t1 [5];
      logic [N-1:0] t2 [10];
      logic [N-1:0] t3 [12];
      logic [N-1:0] t4 [4];
      exp_t e;
      int   wait_cyc;

      t1 = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
      t2 = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1010,
             4'b0101, 4'b1110, 4'b1101, 4'b1011, 4'b1111};
      t3 = '{4'b1000, 4'b0100, 4'b0010, 4'b1100, 4'b0110, 4'b1001,
             4'b1010, 4'b0101, 4'b1110, 4'b1101, 4'b1011, 4'b1111};
      t4 = '{4'd0, 4'd3, 4'd4, 4'd5};

      rst_n = 1'b0;
      a     = 4'b1011;
      shift = 4'd1;
      #3;
      e = model(a, shift);
`ifdef RIGHT_LOGIC_SHIFTER_REG_OUT_EN
      chk("rst_y_q", 32'(y_q), 32'(0), a, shift);
      chk("rst_z_q", 32'(z_q), 32'(1), a, shift);
      chk("rst_c_q", 32'(c_q), 32'(0), a, shift);
`else
      chk("rst_y_q", 32'(y_q), 32'(e.y), a, shift);
      chk("rst_z_q", 32'(z_q), 32'(e.z), a, shift);
      chk("rst_c_q", 32'(c_q), 32'(e.c), a, shift);
`endif
      chk("rst_y", 32'(y), 32'(e.y), a, shift);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      foreach (t1[i]) drive(t1[i], 4'd1);
      foreach (t2[i]) drive(t2[i], 4'd1);
      foreach (t3[i]) drive(t3[i], 4'd2);
      foreach (t4[i]) drive(4'b1011, t4[i]);

      // Exhaustive sweep, inputs changing every cycle
      for (int ai = 0; ai < 16; ai++)
         for (int si = 0; si < 16; si++)
            drive(4'(ai), 4'(si));

      // Random tail
      for (int i = 0; i < 100; i++)
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 50) begin
         @(posedge clk);
         wait_cyc++;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      repeat (2) @(posedge clk);

`ifdef RIGHT_LOGIC_SHIFTER_REG_OUT_EN
      // Asynchronous reset pulse between edges, then first capture
      @(negedge clk);
      a     = 4'b1111;
      shift = 4'd1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("pulse_y_q", 32'(y_q), 32'(0), a, shift);
      chk("pulse_z_q", 32'(z_q), 32'(1), a, shift);
      chk("pulse_c_q", 32'(c_q), 32'(0), a, shift);
      chk("pulse_y",   32'(y),   32'(4'b0111), a, shift);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_y_q", 32'(y_q), 32'(4'b0111), a, shift);
      chk("post_rst_c_q", 32'(c_q), 32'(1), a, shift);

      // Registered output holds the previous value across an input change
      @(negedge clk);
      a = 4'b1000;
      #1;
      chk("hold_y_q", 32'(y_q), 32'(4'b0111), a, shift);
      @(posedge clk);
      #1;
      chk("next_y_q", 32'(y_q), 32'(4'b0100), a, shift);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
